// File: rtl/inst_mem.sv
// inst_mem: zero-latency instruction memory with a byte-serial program loader.
// Loader, FSM and core-reset gating are built only with INST_MEM_LOADER_EN.
module inst_mem #(
  parameter int          DEPTH     = 4096,
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013,
  parameter string       INIT_FILE = "inst.hex"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_o,
  input  logic        load_start_i,
  input  logic [15:0] load_len_i,
  input  logic [7:0]  load_byte_i,
  input  logic        load_valid_i,
  output logic        load_ready_o,
  output logic        load_done_o,
  output logic        load_ovf_o,
  output logic        core_rst_n_o
);

  localparam int MEM_AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A =
    (ADDR_W + 1)'(DEPTH);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic [31:0]       rd_word;
  logic              unused_addr;

  assign idx         = inst_addr_i[ADDR_W+1:2];
  assign in_range    = {1'b0, idx} < DEPTH_A;
  assign rd_word     = mem[idx[MEM_AW-1:0]];
  assign unused_addr = ^{inst_addr_i[31:ADDR_W+2],
                         inst_addr_i[1:0]};

`ifdef INST_MEM_LOADER_EN

  typedef enum logic [1:0] {
    IDLE, LOAD, RELEASE, RUN
  } state_t;

  localparam logic [16:0] DEPTH_P = 17'(DEPTH);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_ptr_q, word_ptr_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] asm_q, asm_d;
  logic        ovf_q, ovf_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        crst_n_q, crst_n_d;
  logic        accept;
  logic        we;
  logic [31:0] wr_word;
  logic [MEM_AW-1:0] wr_addr;

  assign accept  = ready_q & load_valid_i;
  assign wr_word = {load_byte_i, asm_q};
  assign wr_addr = word_ptr_q[MEM_AW-1:0];

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_ptr_d = word_ptr_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    ovf_d      = ovf_q;
    we         = 1'b0;
    unique case (state_q)
      IDLE, RUN: begin
        if (load_start_i) begin
          len_d = load_len_i;
          if (load_len_i == 16'd0) begin
            state_d = RELEASE;
          end else begin
            state_d    = LOAD;
            word_ptr_d = 16'd0;
            byte_cnt_d = 2'd0;
            ovf_d      = 1'b0;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = load_byte_i;
            2'd1: asm_d[15:8]  = load_byte_i;
            2'd2: asm_d[23:16] = load_byte_i;
            default: begin
              // words past the end are dropped
              if ({1'b0, word_ptr_q} < DEPTH_P)
                we = 1'b1;
              else
                ovf_d = 1'b1;
              word_ptr_d = word_ptr_q + 16'd1;
              if (word_ptr_q + 16'd1 == len_q)
                state_d = RELEASE;
            end
          endcase
        end
      end
      RELEASE: state_d = RUN;
      default: state_d = IDLE;
    endcase
    ready_d  = (state_d == LOAD);
    done_d   = (state_d == RELEASE);
    crst_n_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= 16'd0;
      word_ptr_q <= 16'd0;
      byte_cnt_q <= 2'd0;
      asm_q      <= 24'd0;
      ovf_q      <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      crst_n_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_ptr_q <= word_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      ovf_q      <= ovf_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      crst_n_q   <= crst_n_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_word;
  end

  assign load_ready_o = ready_q;
  assign load_done_o  = done_q;
  assign load_ovf_o   = ovf_q;
  assign core_rst_n_o = crst_n_q;
  assign inst_o = (state_q == RUN && in_range)
                ? rd_word : NOP_INST;

`else

  logic [1:0] sync_q, sync_d;
  logic       unused_load;

  assign unused_load = ^{load_start_i, load_len_i,
                         load_byte_i, load_valid_i};

  always_comb sync_d = {sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= sync_d;
  end

  assign load_ready_o = 1'b0;
  assign load_done_o  = 1'b0;
  assign load_ovf_o   = 1'b0;
  assign core_rst_n_o = sync_q[1];
  assign inst_o = in_range ? rd_word : NOP_INST;

`endif

endmodule

// File: tb/tb_inst_mem.sv
// tb_inst_mem: vector table plus scoreboard-driven load sequences.
// Two instances share stimulus: full depth and a 4-word array.
module tb_inst_mem;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_o, inst_o_s;
  logic        load_start_i;
  logic [15:0] load_len_i;
  logic [7:0]  load_byte_i;
  logic        load_valid_i;
  logic        rdy, rdy_s, done, done_s;
  logic        ovf, ovf_s, crst, crst_s;

  always #5 clk = ~clk;

  inst_mem #(.INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_addr_i(inst_addr_i), .inst_o(inst_o),
    .load_start_i(load_start_i),
    .load_len_i(load_len_i),
    .load_byte_i(load_byte_i),
    .load_valid_i(load_valid_i),
    .load_ready_o(rdy), .load_done_o(done),
    .load_ovf_o(ovf), .core_rst_n_o(crst)
  );

  inst_mem #(.DEPTH(4), .ADDR_W(12), .INIT_FILE(""))
  dut_s (
    .clk(clk), .rst_n(rst_n),
    .inst_addr_i(inst_addr_i), .inst_o(inst_o_s),
    .load_start_i(load_start_i),
    .load_len_i(load_len_i),
    .load_byte_i(load_byte_i),
    .load_valid_i(load_valid_i),
    .load_ready_o(rdy_s), .load_done_o(done_s),
    .load_ovf_o(ovf_s), .core_rst_n_o(crst_s)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    bit          sm;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  vec_t        vtab[5];
  exp_t        sb[$];
  logic [31:0] ld_words[$];
  logic [31:0] model_big [int];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic fetch_chk(input string nm, input bit sm,
                           input logic [31:0] a,
                           input logic [31:0] exp);
    @(negedge clk);
    inst_addr_i = a;
    #1;
    chk(nm, sm ? inst_o_s : inst_o, exp);
  endtask

  task automatic run_vtab(input string nm);
    for (int i = 0; i < 5; i++)
      fetch_chk(nm, 1'b1, vtab[i].addr, vtab[i].exp);
  endtask

`ifdef INST_MEM_LOADER_EN

  task automatic start_load(input logic [15:0] len);
    @(negedge clk);
    load_start_i = 1'b1;
    load_len_i   = len;
    @(negedge clk);
    load_start_i = 1'b0;
    load_len_i   = 16'hBEEF;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got 0 exp 1");
    end
    load_valid_i = 1'b1;
    load_byte_i  = b;
    @(negedge clk);
    load_valid_i = 1'b0;
    load_byte_i  = 8'hFF;
  endtask

  task automatic send_words(input int nbytes,
                            input bit gap);
    int cnt = 0;
    for (int k = 0; k < ld_words.size(); k++) begin
      for (int l = 0; l < 4; l++) begin
        if (cnt < nbytes) send_byte(ld_words[k][8*l +: 8]);
        cnt++;
        if (gap && cnt == 2) repeat (5) @(negedge clk);
      end
      if (cnt <= nbytes) begin
        model_big[k] = ld_words[k];
        sb.push_back('{1'b0, 32'(k * 4), ld_words[k]});
        if (k < 4)
          sb.push_back('{1'b1, 32'(k * 4), ld_words[k]});
      end
    end
  endtask

  task automatic full_load(input string nm, input bit gap);
    start_load(16'(ld_words.size()));
    chk({nm, "_rdy"}, 32'(rdy), 32'd1);
    chk({nm, "_crst_lo"}, 32'(crst), 32'd0);
    send_words(4 * ld_words.size(), gap);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_crst_hold"}, 32'(crst), 32'd0);
    chk({nm, "_rdy_off"}, 32'(rdy), 32'd0);
    @(negedge clk);
    chk({nm, "_done_off"}, 32'(done), 32'd0);
    chk({nm, "_crst_hi"}, 32'(crst), 32'd1);
  endtask

  task automatic drain(input string nm);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      fetch_chk(nm, e.sm, e.addr, e.data);
    end
  endtask

  initial begin
    vtab[0] = '{32'h0000_0010, NOP};
    vtab[1] = '{32'h0000_0014, NOP};
    vtab[2] = '{32'h0000_3FFC, NOP};
    vtab[3] = '{32'h0000_0100, NOP};
    vtab[4] = '{32'h0000_0013, NOP};
    rst_n = 1'b1;
    inst_addr_i  = 32'd0;
    load_start_i = 1'b0;
    load_len_i   = 16'd0;
    load_byte_i  = 8'h00;
    load_valid_i = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_crst", 32'(crst), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_inst", inst_o, NOP);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_rdy", 32'(rdy), 32'd0);

    ld_words = '{32'h0010_0513, 32'h0000_0093};
    full_load("len2", 1'b0);
    sb.push_back('{1'b0, 32'h5, 32'h0000_0093});
    drain("len2_fetch");

    ld_words = '{32'h0010_0513, 32'h0000_0093};
    full_load("gap", 1'b1);
    drain("gap_fetch");

    ld_words = '{32'hA000_0000, 32'hA111_1111,
                 32'hA222_2222, 32'hA333_3333,
                 32'hA444_4444, 32'hA555_5555};
    full_load("ovf", 1'b0);
    chk("ovf_small", 32'(ovf_s), 32'd1);
    chk("ovf_big", 32'(ovf), 32'd0);
    drain("ovf_fetch");
    run_vtab("small_oor");

    ld_words = '{32'hDEAD_BEEF};
    start_load(16'd1);
    chk("reload_crst", 32'(crst), 32'd0);
    inst_addr_i = 32'd0;
    #1 chk("reload_nop", inst_o, NOP);
    send_words(4, 1'b0);
    chk("reload_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("reload_ovf_clr", 32'(ovf_s), 32'd0);
    drain("reload_fetch");

    ld_words = '{32'h1122_3344, 32'h5566_7788};
    start_load(16'd2);
    send_words(6, 1'b0);
    sb.delete();
    model_big[0] = 32'h1122_3344;
    @(negedge clk);
    rst_n = 1'b0;
    inst_addr_i = 32'd0;
    #1;
    chk("mrst_crst", 32'(crst), 32'd0);
    chk("mrst_rdy", 32'(rdy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_ovf", 32'(ovf), 32'd0);
    chk("mrst_inst", inst_o, NOP);
    @(negedge clk);
    rst_n = 1'b1;

    start_load(16'd0);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_rdy", 32'(rdy), 32'd0);
    @(negedge clk);
    chk("len0_done_off", 32'(done), 32'd0);
    chk("len0_crst", 32'(crst), 32'd1);
    sb.push_back('{1'b0, 32'h0, model_big[0]});
    sb.push_back('{1'b0, 32'h4, model_big[1]});
    drain("mrst_fetch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

`else

  initial begin
    vtab[0] = '{32'h0000_0010, NOP};
    vtab[1] = '{32'h0000_0014, NOP};
    vtab[2] = '{32'h0000_3FFC, NOP};
    vtab[3] = '{32'h0000_0100, NOP};
    vtab[4] = '{32'h0000_0013, NOP};
    rst_n = 1'b1;
    inst_addr_i  = 32'd0;
    load_start_i = 1'b0;
    load_len_i   = 16'd0;
    load_byte_i  = 8'h00;
    load_valid_i = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_crst", 32'(crst), 32'd0);
    chk("rst_crst_s", 32'(crst_s), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("sync_1", 32'(crst), 32'd0);
    @(negedge clk);
    chk("sync_2", 32'(crst), 32'd1);
    load_start_i = 1'b1;
    load_len_i   = 16'd2;
    load_valid_i = 1'b1;
    @(negedge clk);
    load_start_i = 1'b0;
    @(negedge clk);
    chk("tied_rdy", 32'(rdy), 32'd0);
    chk("tied_done", 32'(done), 32'd0);
    chk("tied_ovf", 32'(ovf_s), 32'd0);
    load_valid_i = 1'b0;
    run_vtab("small_oor");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_crst", 32'(crst), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("resync_1", 32'(crst), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

`endif

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 exp 0");
    $fatal(1, "timeout");
  end

endmodule
